multimode_ff_bank: RTL and testbench
====================================

Name: multimode_ff_bank

Overview:
- Parametrised successor to the single-bit SR flip-flop: a WIDTH-bit bank of edge-triggered flip-flops.
- All bits share one run-time mode: D, T, SR or JK.
- Adds a clock enable, a per-bit sticky illegal-input flag for SR mode, and a saturating illegal-event counter.
- Used as the generic state-holding element in lab datapaths and benches, in place of per-type flip-flop modules.

Parameters:
- WIDTH, 4, number of flip-flop bits in the bank (>=1).
- CNT_W, 4, width of the illegal-event counter (>=1).
- RESET_VAL, 0, value loaded into Q on reset (WIDTH bits).

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- EN  input  1  clock enable; 0 = hold all state.
- MODE  input  2  00=D, 01=T, 10=SR, 11=JK; sampled on each rising edge.
- A  input  WIDTH  per bit: D (D mode), T (T mode), S (SR mode), J (JK mode).
- B  input  WIDTH  per bit: ignored (D/T modes), R (SR mode), K (JK mode).
- CLR_ERR  input  1  synchronous clear of ERR and ERR_CNT.
- Q  output  WIDTH  registered state.
- Q_bar  output  WIDTH  combinational ~Q at all times, including during reset.
- ERR  output  WIDTH  sticky per-bit flag: S=R=1 seen in SR mode.
- ERR_CNT  output  CNT_W  saturating count of cycles with at least one illegal bit.

Behaviour:
- Reset: RST high asynchronously forces Q=RESET_VAL, ERR=0, ERR_CNT=0; holds while RST=1.
- Reset release: first update on the first rising edge with RST=0.
- Reset mid-operation: discards any in-flight state immediately; no partial update.
- Latency: one cycle. Inputs sampled at rising edge N appear on Q after edge N.
- EN=0: Q, ERR and ERR_CNT all hold. CLR_ERR is ignored and no errors are logged.
- Per-bit next state when EN=1 (i = bit index):
  - D mode: Q[i] <= A[i].
  - T mode: Q[i] <= Q[i] ^ A[i].
  - SR mode: (S,R)=00 hold; 01 -> 0; 10 -> 1; 11 illegal, Q[i] holds (see Optional Feature).
  - JK mode: 00 hold; 01 -> 0; 10 -> 1; 11 toggle.
- Illegal mask: ill = A & B when MODE=10, else 0.
- ERR update when EN=1:
  - ERR <= (CLR_ERR ? 0 : ERR) | ill.
  - CLR_ERR and a new illegal event on the same edge: the new bits survive.
- ERR_CNT update when EN=1:
  - base = CLR_ERR ? 0 : ERR_CNT.
  - If ill != 0: ERR_CNT <= base+1, saturating at all-ones; otherwise ERR_CNT <= base.
  - Counts once per cycle, regardless of how many bits are illegal.
  - At saturation further events hold the all-ones value; CLR_ERR returns the count to 0 (or 1 if an event occurs on the same edge).
- MODE change: takes effect on the edge it is sampled. State carries across modes untouched; no reset on a mode switch.
- No latch or combinational path from inputs to Q. Q_bar depends only on Q.

Optional Feature:
- Macro: MULTIMODE_FF_BANK_SET_DOM_EN.
- Defined: SR-mode S=R=1 resolves set-dominant (Q[i] <= 1). ERR and ERR_CNT logging is unchanged.
- Undefined: S=R=1 holds Q[i], as above.
- No other behaviour differs between the two builds.

Test Plan (WIDTH=4, CNT_W=2, RESET_VAL=4'b1010):
- Reset: assert RST mid-cycle with Q=4'b0110 -> Q=1010 and Q_bar=0101 immediately; ERR=0, ERR_CNT=0; Q unchanged at the first edge after release when EN=0.
- D/T modes: MODE=00, A=0011 -> Q=0011 next edge; MODE=01, A=0101 -> Q=0110; EN=0 for 3 edges -> Q stays 0110.
- SR mode: Q=0000, A=0011, B=0101 -> bit0 illegal holds 0, bit1 set, bit2 reset -> Q=0010, ERR=0001, ERR_CNT=1. With the macro defined, Q=0011.
- JK mode: Q=0010, A=1111, B=1100 -> Q=1111; then A=B=1111 -> Q=0000; ERR and ERR_CNT unchanged.
- Counter saturation: 5 consecutive SR cycles with A=B=0001 -> ERR_CNT 1,2,3,3,3.
- Clear: CLR_ERR=1 alone -> ERR=0, ERR_CNT=0. CLR_ERR=1 with A=B=1000 in SR mode -> ERR=1000, ERR_CNT=1.

Source files
------------

// File: rtl/multimode_ff_bank.sv
// multimode_ff_bank: WIDTH-bit bank of flip-flops sharing one run-time mode
// (D / T / SR / JK). It has a clock enable, a sticky per-bit flag for illegal
// SR inputs, and a saturating counter of cycles that had an illegal input.
// Optional build macro: MULTIMODE_FF_BANK_SET_DOM_EN. When it is defined,
// S=R=1 in SR mode sets the bit. When it is undefined, S=R=1 holds the bit.

// Per-bit cell: next-state selection plus the state register for one bit.
module multimode_ff_cell #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] mode,
  input  logic       a,
  input  logic       b,
  output logic       q
);

  logic q_nxt;

  // Next-state decode for the selected flip-flop type
  always_comb begin
    q_nxt = q;
    unique case (mode)
      2'b00: q_nxt = a;
      2'b01: q_nxt = q ^ a;
      2'b10: begin
        unique case ({a, b})
          2'b00: q_nxt = q;
          2'b01: q_nxt = 1'b0;
          2'b10: q_nxt = 1'b1;
`ifdef MULTIMODE_FF_BANK_SET_DOM_EN
          2'b11: q_nxt = 1'b1;
`else
          2'b11: q_nxt = q;
`endif
          default: q_nxt = q;
        endcase
      end
      2'b11: begin
        unique case ({a, b})
          2'b00: q_nxt = q;
          2'b01: q_nxt = 1'b0;
          2'b10: q_nxt = 1'b1;
          2'b11: q_nxt = ~q;
          default: q_nxt = q;
        endcase
      end
      default: q_nxt = q;
    endcase
  end

  // State register: asynchronous reset, update gated by enable
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= RST_VAL;
    else if (en) q <= q_nxt;
  end

endmodule

module multimode_ff_bank #(
  parameter int               WIDTH     = 4,
  parameter int               CNT_W     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CLR_ERR,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_bar,
  output logic [WIDTH-1:0] ERR,
  output logic [CNT_W-1:0] ERR_CNT
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] ill;
  logic [WIDTH-1:0] err_nxt;
  logic [CNT_W-1:0] cnt_base;
  logic [CNT_W-1:0] cnt_nxt;

  // One cell per bit, all sharing the same mode and enable
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    multimode_ff_cell #(.RST_VAL(RESET_VAL[i])) u_cell (
      .clk  (CLK),
      .rst  (RST),
      .en   (EN),
      .mode (MODE),
      .a    (A[i]),
      .b    (B[i]),
      .q    (Q[i])
    );
  end

  // Q_bar depends only on Q, so it already tracks Q during reset
  assign Q_bar = ~Q;

  // Illegal-input mask and next error state. A clear on the same edge as a
  // new illegal event keeps the new event.
  always_comb begin
    ill      = (MODE == 2'b10) ? (A & B) : '0;
    err_nxt  = (CLR_ERR ? '0 : ERR) | ill;
    cnt_base = CLR_ERR ? '0 : ERR_CNT;
    cnt_nxt  = cnt_base;
    if (|ill && cnt_base != CNT_MAX) cnt_nxt = cnt_base + CNT_W'(1);
  end

  // Error flag and counter registers. While enable is low, a clear is ignored.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ERR     <= '0;
      ERR_CNT <= '0;
    end else if (EN) begin
      ERR     <= err_nxt;
      ERR_CNT <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_multimode_ff_bank.sv
// Directed bench for multimode_ff_bank (WIDTH=4, CNT_W=2, RESET_VAL=1010).
// Expected Q values follow MULTIMODE_FF_BANK_SET_DOM_EN when that macro is defined.
`timescale 1ns/1ps
module tb_multimode_ff_bank;

  logic       CLK = 1'b0;
  logic       RST, EN, CLR_ERR;
  logic [1:0] MODE;
  logic [3:0] A, B, Q, Q_bar, ERR;
  logic [1:0] ERR_CNT;

  int n_run  = 0;
  int n_fail = 0;

`ifdef MULTIMODE_FF_BANK_SET_DOM_EN
  localparam bit SD = 1'b1;
`else
  localparam bit SD = 1'b0;
`endif

  multimode_ff_bank #(.WIDTH(4), .CNT_W(2), .RESET_VAL(4'b1010)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .MODE(MODE), .A(A), .B(B),
    .CLR_ERR(CLR_ERR), .Q(Q), .Q_bar(Q_bar), .ERR(ERR), .ERR_CNT(ERR_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    RST = 1'b1; EN = 1'b0; CLR_ERR = 1'b0; MODE = 2'b00; A = '0; B = '0;
    tick(); tick();
    chk("rst_q", 8'(Q), 8'h0a);
    chk("rst_err", 8'(ERR), 8'h00);
    chk("rst_cnt", 8'(ERR_CNT), 8'h0);
    RST = 1'b0;

    // Load 0110, then reset in the middle of a cycle
    EN = 1'b1; MODE = 2'b00; A = 4'b0110;
    tick();
    chk("pre_rst_q", 8'(Q), 8'h06);
    #2 RST = 1'b1;
    #1;
    chk("midrst_q", 8'(Q), 8'h0a);
    chk("midrst_qbar", 8'(Q_bar), 8'h05);
    chk("midrst_err", 8'(ERR), 8'h00);
    chk("midrst_cnt", 8'(ERR_CNT), 8'h0);
    tick();
    RST = 1'b0; EN = 1'b0; A = 4'b0101;
    tick();
    chk("rel_en0_q", 8'(Q), 8'h0a);

    // D and T modes
    EN = 1'b1; MODE = 2'b00; A = 4'b0011; B = 4'b1111;
    tick();
    chk("d_q", 8'(Q), 8'h03);
    chk("d_qbar", 8'(Q_bar), 8'h0c);
    MODE = 2'b01; A = 4'b0101;
    tick();
    chk("t_q", 8'(Q), 8'h06);
    EN = 1'b0; MODE = 2'b00; A = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("en0_hold_q", 8'(Q), 8'h06);
    end

    // SR mode: bit0 is illegal, bit1 is set, bit2 is reset
    EN = 1'b1; MODE = 2'b00; A = 4'b0000; B = 4'b0000;
    tick();
    chk("zero_q", 8'(Q), 8'h00);
    MODE = 2'b10; A = 4'b0011; B = 4'b0101;
    tick();
    chk("sr_q", 8'(Q), SD ? 8'h03 : 8'h02);
    chk("sr_err", 8'(ERR), 8'h01);
    chk("sr_cnt", 8'(ERR_CNT), 8'h1);

    // JK mode
    MODE = 2'b11; A = 4'b1111; B = 4'b1100;
    tick();
    chk("jk_q", 8'(Q), 8'h0f);
    A = 4'b1111; B = 4'b1111;
    tick();
    chk("jk_tog_q", 8'(Q), 8'h00);
    chk("jk_err", 8'(ERR), 8'h01);
    chk("jk_cnt", 8'(ERR_CNT), 8'h1);

    // Clear on its own, then drive the counter to saturation
    CLR_ERR = 1'b1; MODE = 2'b00; A = 4'b0000; B = 4'b0000;
    tick();
    chk("clr_err", 8'(ERR), 8'h00);
    chk("clr_cnt", 8'(ERR_CNT), 8'h0);
    CLR_ERR = 1'b0; MODE = 2'b10; A = 4'b0001; B = 4'b0001;
    tick(); chk("sat_cnt1", 8'(ERR_CNT), 8'h1);
    tick(); chk("sat_cnt2", 8'(ERR_CNT), 8'h2);
    tick(); chk("sat_cnt3", 8'(ERR_CNT), 8'h3);
    tick(); chk("sat_cnt4", 8'(ERR_CNT), 8'h3);
    tick(); chk("sat_cnt5", 8'(ERR_CNT), 8'h3);
    chk("sat_err", 8'(ERR), 8'h01);
    chk("sat_q", 8'(Q), SD ? 8'h01 : 8'h00);

    // With EN low, neither a clear nor an illegal input has any effect
    EN = 1'b0; CLR_ERR = 1'b1; A = 4'b1111; B = 4'b1111;
    tick();
    chk("en0_err", 8'(ERR), 8'h01);
    chk("en0_cnt", 8'(ERR_CNT), 8'h3);

    // Clear on the same edge as a new event: the new event survives
    EN = 1'b1; CLR_ERR = 1'b1; MODE = 2'b10; A = 4'b1000; B = 4'b1000;
    tick();
    chk("clr_ev_err", 8'(ERR), 8'h08);
    chk("clr_ev_cnt", 8'(ERR_CNT), 8'h1);
    chk("clr_ev_q", 8'(Q), SD ? 8'h09 : 8'h00);

    // Several illegal bits in one cycle count only once
    CLR_ERR = 1'b0; A = 4'b0011; B = 4'b0011;
    tick();
    chk("multi_err", 8'(ERR), 8'h0b);
    chk("multi_cnt", 8'(ERR_CNT), 8'h2);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
